// File: rtl/fruit_motion.sv
// Per-fruit motion engine: launches a fruit from the bottom edge, applies
// velocity and gravity once per frame, bounces off the side walls and
// reports slice / miss events to the game controller.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no fruit on screen, waiting for a launch request
// FLYING | fruit in flight, physics running, can be sliced or missed
// SLICED | split-fruit art shown, physics running with vx held at 0,
//        | returns to IDLE after SLICE_FRAMES ticks or on bottom exit
module fruit_motion #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int SIZE         = 16,
  parameter int GRAVITY      = 1,
  parameter int SLICE_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       launch,
  input  logic [9:0] launch_x,
  input  logic [3:0] launch_vx,
  input  logic [5:0] launch_vy,
  input  logic       slice,
  output logic [9:0] FruitX,
  output logic [9:0] FruitY,
  output logic [9:0] Fruit_size,
  output logic       fruit_on,
  output logic       fruit_sliced,
  output logic       sliced_pulse,
  output logic       missed_pulse
);

  localparam int CNT_W = $clog2(SLICE_FRAMES + 1);

  // Physics runs in signed 12-bit so negative intermediate positions are visible.
  localparam logic signed [11:0] X_MIN_S   = 12'(X_MIN);
  localparam logic signed [11:0] X_LIM_S   = 12'(X_MAX + 1 - SIZE);
  localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
  localparam logic signed [11:0] GRAV_S    = 12'(GRAVITY);
  localparam logic signed [11:0] VY_SAT_S  = 12'sd31;
  localparam logic signed [11:0] ZERO_S    = 12'sd0;
  localparam logic [9:0]         X_LIM     = 10'(X_MAX + 1 - SIZE);
  localparam logic [9:0]         Y_SPAWN   = 10'(Y_MAX + 1 - SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    SLICED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         fx_q, fx_d;
  logic [9:0]         fy_q, fy_d;
  logic signed [11:0] vx_q, vx_d;
  logic signed [11:0] vy_q, vy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_clk_q;
  logic               sliced_pulse_q, sliced_pulse_d;
  logic               missed_pulse_q, missed_pulse_d;

  logic               frame_tick;
  logic signed [11:0] x_sum, y_sum, vy_base, vy_sum;
  logic [9:0]         phys_x, phys_y;
  logic signed [11:0] phys_vx, phys_vy;
  logic               y_exit;

  assign frame_tick = frame_clk & ~frame_clk_q;

  // One-frame physics step computed from the current registered state.
  always_comb begin
    x_sum   = $signed({2'b00, fx_q}) + vx_q;
    y_sum   = $signed({2'b00, fy_q}) + vy_q;
    phys_vx = vx_q;
    vy_base = vy_q;
    phys_x  = x_sum[9:0];
    phys_y  = y_sum[9:0];
    if (x_sum < X_MIN_S) begin
      phys_x  = X_MIN_S[9:0];
      phys_vx = -vx_q;
    end else if (x_sum > X_LIM_S) begin
      phys_x  = X_LIM;
      phys_vx = -vx_q;
    end
    if (y_sum < ZERO_S) begin
      phys_y  = 10'd0;
      vy_base = ZERO_S;
    end
    vy_sum  = vy_base + GRAV_S;
    phys_vy = (vy_sum > VY_SAT_S) ? VY_SAT_S : vy_sum;
    y_exit  = (y_sum > Y_MAX_S);
  end

  // Next-state, motion register and event pulse decode.
  always_comb begin
    state_d        = state_q;
    fx_d           = fx_q;
    fy_d           = fy_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    cnt_d          = cnt_q;
    sliced_pulse_d = 1'b0;
    missed_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = FLYING;
          fx_d    = (launch_x > X_LIM) ? X_LIM : launch_x;
          fy_d    = Y_SPAWN;
          vx_d    = {{8{launch_vx[3]}}, launch_vx};
          vy_d    = {{6{launch_vy[5]}}, launch_vy};
        end
      end
      FLYING: begin
        if (frame_tick) begin
          fx_d = phys_x;
          fy_d = phys_y;
          vx_d = phys_vx;
          vy_d = phys_vy;
        end
        // A slice in the same cycle as an exit wins: the fruit counts as hit.
        if (slice) begin
          state_d        = SLICED;
          sliced_pulse_d = 1'b1;
          cnt_d          = CNT_W'(SLICE_FRAMES);
          vx_d           = ZERO_S;
        end else if (frame_tick && y_exit) begin
          state_d        = IDLE;
          missed_pulse_d = 1'b1;
        end
      end
      SLICED: begin
        if (frame_tick) begin
          fx_d  = phys_x;
          fy_d  = phys_y;
          vx_d  = phys_vx;
          vy_d  = phys_vy;
          cnt_d = cnt_q - CNT_W'(1);
          if ((cnt_q <= CNT_W'(1)) || y_exit) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and motion registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      fx_q           <= 10'd0;
      fy_q           <= Y_SPAWN;
      vx_q           <= ZERO_S;
      vy_q           <= ZERO_S;
      cnt_q          <= '0;
      frame_clk_q    <= 1'b0;
      sliced_pulse_q <= 1'b0;
      missed_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fx_q           <= fx_d;
      fy_q           <= fy_d;
      vx_q           <= vx_d;
      vy_q           <= vy_d;
      cnt_q          <= cnt_d;
      frame_clk_q    <= frame_clk;
      sliced_pulse_q <= sliced_pulse_d;
      missed_pulse_q <= missed_pulse_d;
    end
  end

  assign FruitX       = fx_q;
  assign FruitY       = fy_q;
  assign Fruit_size   = 10'(SIZE);
  assign fruit_on     = (state_q != IDLE);
  assign fruit_sliced = (state_q == SLICED);
  assign sliced_pulse = sliced_pulse_q;
  assign missed_pulse = missed_pulse_q;

endmodule

// File: tb/tb_fruit_motion.sv
// Directed bench for fruit_motion: flight profile, miss, wall bounce,
// slice timing, ignored inputs, slice/exit tie and asynchronous reset.
module tb_fruit_motion;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       launch;
  logic [9:0] launch_x;
  logic [3:0] launch_vx;
  logic [5:0] launch_vy;
  logic       slice;
  logic [9:0] FruitX;
  logic [9:0] FruitY;
  logic [9:0] Fruit_size;
  logic       fruit_on;
  logic       fruit_sliced;
  logic       sliced_pulse;
  logic       missed_pulse;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_missed = 0;
  int   n_sliced = 0;
  int   n_overlap = 0;
  logic mp_seen = 1'b0;
  logic sp_seen = 1'b0;
  int   base_m, base_s;

  fruit_motion dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .launch       (launch),
    .launch_x     (launch_x),
    .launch_vx    (launch_vx),
    .launch_vy    (launch_vy),
    .slice        (slice),
    .FruitX       (FruitX),
    .FruitY       (FruitY),
    .Fruit_size   (Fruit_size),
    .fruit_on     (fruit_on),
    .fruit_sliced (fruit_sliced),
    .sliced_pulse (sliced_pulse),
    .missed_pulse (missed_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse width / overlap monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (missed_pulse === 1'b1) n_missed++;
    if (sliced_pulse === 1'b1) n_sliced++;
    if (missed_pulse === 1'b1 && sliced_pulse === 1'b1) n_overlap++;
  end

  // One frame tick; optional slice in the same Clk as the tick.
  task automatic tick(input logic s);
    frame_clk = 1'b1;
    slice     = s;
    @(posedge Clk); #1;
    mp_seen   = missed_pulse;
    sp_seen   = sliced_pulse;
    frame_clk = 1'b0;
    slice     = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic do_launch(input logic [9:0] x, input logic [3:0] vx, input logic [5:0] vy);
    launch    = 1'b1;
    launch_x  = x;
    launch_vx = vx;
    launch_vy = vy;
    @(posedge Clk); #1;
    launch    = 1'b0;
  endtask

  task automatic fly_out();
    int k;
    k = 0;
    while (fruit_on === 1'b1 && k < 100) begin
      tick(1'b0);
      k++;
    end
    n_cmp++;
    if (fruit_on !== 1'b0) begin
      n_bad++;
      $display("FAIL fly_out_timeout: fruit_on got %0b expected 0", fruit_on);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++;
    if (FruitX !== 10'd0) begin n_bad++; $display("FAIL rst_x: got %0d expected 0", FruitX); end
    n_cmp++;
    if (FruitY !== 10'd464) begin n_bad++; $display("FAIL rst_y: got %0d expected 464", FruitY); end
    n_cmp++;
    if (Fruit_size !== 10'd16) begin n_bad++; $display("FAIL rst_size: got %0d expected 16", Fruit_size); end
    n_cmp++;
    if ({fruit_on, fruit_sliced, sliced_pulse, missed_pulse} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_flags: got %b expected 0000", {fruit_on, fruit_sliced, sliced_pulse, missed_pulse});
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_flight();
    do_launch(10'd300, 4'd0, 6'(-10));
    n_cmp++;
    if (FruitY !== 10'd464 || fruit_on !== 1'b1) begin
      n_bad++;
      $display("FAIL flight_spawn: y=%0d on=%0b expected y=464 on=1", FruitY, fruit_on);
    end
    tick(1'b0);
    n_cmp++;
    if (FruitY !== 10'd454) begin n_bad++; $display("FAIL flight_y1: got %0d expected 454", FruitY); end
    tick(1'b0);
    n_cmp++;
    if (FruitY !== 10'd445) begin n_bad++; $display("FAIL flight_y2: got %0d expected 445", FruitY); end
    tick(1'b0);
    n_cmp++;
    if (FruitY !== 10'd437) begin n_bad++; $display("FAIL flight_y3: got %0d expected 437", FruitY); end
    ticks(7);
    n_cmp++;
    if (FruitY !== 10'd409) begin n_bad++; $display("FAIL flight_apex: got %0d expected 409", FruitY); end
    n_cmp++;
    if (FruitX !== 10'd300) begin n_bad++; $display("FAIL flight_x: got %0d expected 300", FruitX); end
  endtask

  task automatic test_miss();
    base_m = n_missed;
    ticks(12);
    n_cmp++;
    if (FruitY !== 10'd475 || n_missed != base_m) begin
      n_bad++;
      $display("FAIL miss_pre: y=%0d misses=%0d expected y=475 misses=0", FruitY, n_missed - base_m);
    end
    tick(1'b0);
    n_cmp++;
    if (mp_seen !== 1'b1) begin n_bad++; $display("FAIL miss_pulse: got %0b expected 1", mp_seen); end
    n_cmp++;
    if (n_missed - base_m != 1) begin n_bad++; $display("FAIL miss_width: got %0d expected 1", n_missed - base_m); end
    n_cmp++;
    if (fruit_on !== 1'b0) begin n_bad++; $display("FAIL miss_idle: fruit_on got %0b expected 0", fruit_on); end
  endtask

  task automatic test_wall();
    do_launch(10'd620, 4'd5, 6'(-10));
    n_cmp++;
    if (FruitX !== 10'd620) begin n_bad++; $display("FAIL wall_x0: got %0d expected 620", FruitX); end
    tick(1'b0);
    n_cmp++;
    if (FruitX !== 10'd624) begin n_bad++; $display("FAIL wall_x1: got %0d expected 624", FruitX); end
    tick(1'b0);
    n_cmp++;
    if (FruitX !== 10'd619) begin n_bad++; $display("FAIL wall_x2: got %0d expected 619", FruitX); end
    fly_out();
    do_launch(10'd700, 4'd0, 6'(-10));
    n_cmp++;
    if (FruitX !== 10'd624) begin n_bad++; $display("FAIL wall_clamp: got %0d expected 624", FruitX); end
    fly_out();
    do_launch(10'd3, 4'(-5), 6'(-10));
    tick(1'b0);
    n_cmp++;
    if (FruitX !== 10'd0) begin n_bad++; $display("FAIL wall_left1: got %0d expected 0", FruitX); end
    tick(1'b0);
    n_cmp++;
    if (FruitX !== 10'd5) begin n_bad++; $display("FAIL wall_left2: got %0d expected 5", FruitX); end
    fly_out();
  endtask

  task automatic test_slice();
    base_m = n_missed;
    base_s = n_sliced;
    do_launch(10'd100, 4'd3, 6'(-25));
    ticks(2);
    tick(1'b1);
    n_cmp++;
    if (sp_seen !== 1'b1 || fruit_sliced !== 1'b1) begin
      n_bad++;
      $display("FAIL slice_enter: pulse=%0b sliced=%0b expected 1 1", sp_seen, fruit_sliced);
    end
    n_cmp++;
    if (FruitX !== 10'd109 || FruitY !== 10'd392) begin
      n_bad++;
      $display("FAIL slice_pos3: x=%0d y=%0d expected x=109 y=392", FruitX, FruitY);
    end
    tick(1'b0);
    n_cmp++;
    if (FruitX !== 10'd109 || FruitY !== 10'd370) begin
      n_bad++;
      $display("FAIL slice_pos4: x=%0d y=%0d expected x=109 y=370", FruitX, FruitY);
    end
    ticks(5);
    tick(1'b1);
    ticks(22);
    n_cmp++;
    if (fruit_on !== 1'b1 || fruit_sliced !== 1'b1) begin
      n_bad++;
      $display("FAIL slice_hold32: on=%0b sliced=%0b expected 1 1", fruit_on, fruit_sliced);
    end
    tick(1'b0);
    n_cmp++;
    if (fruit_on !== 1'b0 || fruit_sliced !== 1'b0) begin
      n_bad++;
      $display("FAIL slice_end33: on=%0b sliced=%0b expected 0 0", fruit_on, fruit_sliced);
    end
    n_cmp++;
    if (n_sliced - base_s != 1 || n_missed != base_m) begin
      n_bad++;
      $display("FAIL slice_pulses: sliced=%0d missed=%0d expected 1 0", n_sliced - base_s, n_missed - base_m);
    end
  endtask

  task automatic test_ignore_and_tie();
    base_m = n_missed;
    base_s = n_sliced;
    do_launch(10'd300, 4'd0, 6'(-10));
    tick(1'b0);
    do_launch(10'd50, 4'd7, 6'd0);
    n_cmp++;
    if (FruitX !== 10'd300 || FruitY !== 10'd454 || fruit_sliced !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_launch: x=%0d y=%0d sl=%0b expected 300 454 0", FruitX, FruitY, fruit_sliced);
    end
    tick(1'b0);
    n_cmp++;
    if (FruitY !== 10'd445) begin n_bad++; $display("FAIL ignore_vy: got %0d expected 445", FruitY); end
    ticks(20);
    n_cmp++;
    if (FruitY !== 10'd475) begin n_bad++; $display("FAIL tie_pre: got %0d expected 475", FruitY); end
    tick(1'b1);
    n_cmp++;
    if (sp_seen !== 1'b1 || mp_seen !== 1'b0 || fruit_sliced !== 1'b1) begin
      n_bad++;
      $display("FAIL tie_pulses: sp=%0b mp=%0b sl=%0b expected 1 0 1", sp_seen, mp_seen, fruit_sliced);
    end
    tick(1'b0);
    n_cmp++;
    if (fruit_on !== 1'b0 || n_missed != base_m || n_sliced - base_s != 1) begin
      n_bad++;
      $display("FAIL tie_exit: on=%0b missed=%0d sliced=%0d expected 0 0 1", fruit_on, n_missed - base_m, n_sliced - base_s);
    end
  endtask

  task automatic test_async_reset();
    do_launch(10'd200, 4'd2, 6'(-10));
    ticks(2);
    #3;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (FruitX !== 10'd0 || FruitY !== 10'd464) begin
      n_bad++;
      $display("FAIL arst_pos: x=%0d y=%0d expected 0 464", FruitX, FruitY);
    end
    n_cmp++;
    if ({fruit_on, fruit_sliced, sliced_pulse, missed_pulse} !== 4'b0000) begin
      n_bad++;
      $display("FAIL arst_flags: got %b expected 0000", {fruit_on, fruit_sliced, sliced_pulse, missed_pulse});
    end
    #2;
    Reset = 1'b0;
    do_launch(10'd200, 4'd0, 6'(-10));
    n_cmp++;
    if (FruitX !== 10'd200 || fruit_on !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_relaunch: x=%0d on=%0b expected 200 1", FruitX, fruit_on);
    end
    fly_out();
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    launch    = 1'b0;
    launch_x  = 10'd0;
    launch_vx = 4'd0;
    launch_vy = 6'd0;
    slice     = 1'b0;
    test_reset();
    test_flight();
    test_miss();
    test_wall();
    test_slice();
    test_ignore_and_tie();
    test_async_reset();
    n_cmp++;
    if (n_overlap != 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d expected 0", n_overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
